// File: rtl/svm_scheduler.sv
// Fall-detection scheduler: accumulates a window of samples, derives mean and
// standard deviation, hands them to an external SVM and confirms positive results.
module svm_scheduler #(
  parameter int WINDOW  = 32,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_data,
  output logic               sample_ready,
  output logic               svm_start,
  output logic signed [31:0] feature_mean,
  output logic signed [31:0] feature_std,
  input  logic               svm_done,
  input  logic               svm_result,
  output logic               fall_alarm,
  input  logic               alarm_clear,
  output logic               timeout_err,
  output logic               busy
);
  localparam int LG = $clog2(WINDOW);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_VAR    = 3'd2;
  localparam logic [2:0] S_SQRT   = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_DECIDE = 3'd6;

  logic [2:0]         state;
  logic [8:0]         cnt;
  logic signed [23:0] sum;
  logic [39:0]        sumsq;
  logic signed [31:0] mean_q;
  logic [31:0]        rad;
  logic [19:0]        rem;
  logic [15:0]        root;
  logic [3:0]         bitc;
  logic [15:0]        wcnt;
  logic [3:0]         conf;

  logic               accept;
  logic signed [31:0] sd32, sq;
  logic signed [31:0] sum_x, mean_c;
  logic signed [33:0] mx, msq;
  logic [39:0]        sq_sh;
  logic signed [41:0] diff;
  logic [31:0]        var_c;
  logic [19:0]        rem_n, trial;
  logic               ge;
  logic [19:0]        rem_nxt;
  logic [15:0]        root_nxt;
  logic               wait_expired;
  logic [3:0]         conf_inc;

  assign sample_ready = (state == S_ACCUM) && enable;
  assign accept       = sample_ready && sample_valid;
  assign svm_start    = (state == S_START);
  assign busy         = (state != S_IDLE) && (state != S_ACCUM);

  assign sd32 = {{16{sample_data[15]}}, sample_data};
  assign sq   = sd32 * sd32;

  // Mean is floor(sum / WINDOW); it always fits the 16-bit sample range,
  // so its square is formed at 34 bits.
  assign sum_x  = {{8{sum[23]}}, sum};
  assign mean_c = sum_x >>> LG;
  assign mx     = {{17{mean_c[16]}}, mean_c[16:0]};
  assign msq    = mx * mx;
  assign sq_sh  = sumsq >> LG;
  assign diff   = $signed({2'b00, sq_sh}) - $signed({{8{msq[33]}}, msq});

  always_comb begin
    var_c = diff[31:0];
    if (diff[41])            var_c = 32'd0;
    else if (|diff[40:32])   var_c = 32'hFFFF_FFFF;
  end

  // Restoring square root: two radicand bits in, one root bit out per cycle.
  assign rem_n    = {rem[17:0], rad[31:30]};
  assign trial    = {2'b00, root, 2'b01};
  assign ge       = (rem_n >= trial);
  assign rem_nxt  = ge ? (rem_n - trial) : rem_n;
  assign root_nxt = {root[14:0], ge};

  assign wait_expired = (state == S_WAIT) && !svm_done && (wcnt == 16'(TIMEOUT));
  assign conf_inc     = (conf == 4'd15) ? 4'd15 : conf + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sum          <= '0;
      sumsq        <= '0;
      mean_q       <= '0;
      rad          <= '0;
      rem          <= '0;
      root         <= '0;
      bitc         <= '0;
      wcnt         <= '0;
      feature_mean <= '0;
      feature_std  <= '0;
      timeout_err  <= 1'b0;
    end else if (!enable) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_ACCUM;
          cnt   <= '0;
          sum   <= '0;
          sumsq <= '0;
        end
        S_ACCUM: begin
          if (accept) begin
            sum   <= sum + sd32[23:0];
            sumsq <= sumsq + {8'd0, sq};
            cnt   <= cnt + 9'd1;
            if (cnt == 9'(WINDOW - 1)) state <= S_VAR;
          end
        end
        S_VAR: begin
          mean_q <= mean_c;
          rad    <= var_c;
          rem    <= '0;
          root   <= '0;
          bitc   <= '0;
          state  <= S_SQRT;
        end
        S_SQRT: begin
          rem  <= rem_nxt;
          root <= root_nxt;
          rad  <= {rad[29:0], 2'b00};
          bitc <= bitc + 4'd1;
          if (bitc == 4'd15) begin
            feature_mean <= mean_q;
            feature_std  <= {16'd0, root_nxt};
            state        <= S_START;
          end
        end
        S_START: begin
          wcnt  <= 16'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (svm_done) begin
            state <= S_DECIDE;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            sum         <= '0;
            sumsq       <= '0;
            state       <= S_ACCUM;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_DECIDE: begin
          cnt   <= '0;
          sum   <= '0;
          sumsq <= '0;
          state <= S_ACCUM;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear beats any simultaneous set and zeroes the confirm counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conf       <= '0;
      fall_alarm <= 1'b0;
    end else if (alarm_clear) begin
      conf       <= '0;
      fall_alarm <= 1'b0;
    end else if (enable && wait_expired) begin
      conf <= '0;
    end else if (enable && state == S_DECIDE) begin
      conf <= svm_result ? conf_inc : 4'd0;
      if (svm_result && conf_inc >= 4'(CONFIRM)) fall_alarm <= 1'b1;
    end
  end
endmodule

// File: tb/tb_svm_scheduler.sv
// Directed bench for svm_scheduler: statistics, latency, confirm/alarm,
// timeout, back-pressure, enable drop and asynchronous reset.
module tb_svm_scheduler;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_valid = 1'b0;
  logic signed [15:0] sample_data = '0;
  logic svm_done = 1'b0, svm_result = 1'b0, alarm_clear = 1'b0;
  logic sample_ready, svm_start, fall_alarm, timeout_err, busy;
  logic signed [31:0] feature_mean, feature_std;

  int tests = 0, fails = 0, cyc = 0, last_cyc = 0, got_lat = 0;
  logic signed [31:0] got_mean, got_std;
  int exp_mean [5] = '{100, 0, -7, 1, -1};
  int exp_std  [5] = '{0, 100, 0, 1, 0};

  svm_scheduler #(.WINDOW(32), .CONFIRM(2), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .svm_start(svm_start), .feature_mean(feature_mean), .feature_std(feature_std),
    .svm_done(svm_done), .svm_result(svm_result), .fall_alarm(fall_alarm),
    .alarm_clear(alarm_clear), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] sval(input int mode, input int k);
    case (mode)
      0: return 16'sd100;
      1: return (k % 2 == 1) ? -16'sd100 : 16'sd100;
      2: return -16'sd7;
      3: return (k < 16) ? 16'sd3 : 16'sd0;
      4: return (k == 31) ? -16'sd1 : 16'sd0;
      5: return (k % 2 == 1) ? -16'sd50 : 16'sd50;
      default: return 16'sd0;
    endcase
  endfunction

  task automatic feed(input int mode, input int n, input bit rnd);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (rnd && $urandom_range(0, 2) == 0) begin
        sample_valid = 1'b0;
        sample_data  = 16'sh7fff;
      end else begin
        sample_valid = 1'b1;
        sample_data  = sval(mode, k);
      end
      if (sample_valid && sample_ready) begin
        last_cyc = cyc;
        k++;
      end
    end
    @(posedge clk);
    #1 sample_valid = 1'b0;
    tests++;
    if (k != n) begin
      fails++;
      $display("FAIL feed_stall accepted=%0d want=%0d", k, n);
    end
  endtask

  task automatic wait_start();
    got_lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (svm_start) begin
        got_lat  = cyc - last_cyc;
        got_mean = feature_mean;
        got_std  = feature_std;
        break;
      end
    end
  endtask

  // Entered at the negedge of the start cycle; leaves at the first ACCUM cycle.
  task automatic respond(input bit res, input bit clr);
    @(negedge clk); svm_done = 1'b1; svm_result = res;
    @(negedge clk); svm_done = 1'b0; alarm_clear = clr;
    @(negedge clk); alarm_clear = 1'b0;
  endtask

  task automatic run(input int mode, input bit rnd, input bit res, input bit clr);
    feed(mode, 32, rnd);
    wait_start();
    respond(res, clr);
  endtask

  task automatic test_reset();
    tests++;
    if ({sample_ready, svm_start, fall_alarm, timeout_err, busy} !== 5'b0 ||
        feature_mean !== 32'sd0 || feature_std !== 32'sd0) begin
      fails++;
      $display("FAIL reset_state ctl=%b mean=%0d std=%0d want all zero",
               {sample_ready, svm_start, fall_alarm, timeout_err, busy}, feature_mean, feature_std);
    end
  endtask

  task automatic test_stats();
    for (int m = 0; m < 5; m++) begin
      feed(m, 32, 1'b0);
      wait_start();
      tests++;
      if (got_lat !== 18) begin fails++; $display("FAIL latency mode%0d got=%0d want=18", m, got_lat); end
      tests++;
      if (got_mean !== exp_mean[m]) begin fails++; $display("FAIL mean mode%0d got=%0d want=%0d", m, got_mean, exp_mean[m]); end
      tests++;
      if (got_std !== exp_std[m]) begin fails++; $display("FAIL std mode%0d got=%0d want=%0d", m, got_std, exp_std[m]); end
      respond(1'b0, 1'b0);
      tests++;
      if (feature_mean !== exp_mean[m] || sample_ready !== 1'b1) begin
        fails++;
        $display("FAIL hold mode%0d mean=%0d ready=%b want mean=%0d ready=1", m, feature_mean, sample_ready, exp_mean[m]);
      end
    end
  endtask

  task automatic test_backpressure();
    feed(5, 32, 1'b1);
    wait_start();
    tests++;
    if (got_mean !== 32'sd0 || got_std !== 32'sd50) begin
      fails++;
      $display("FAIL backpressure mean=%0d std=%0d want 0/50", got_mean, got_std);
    end
    respond(1'b0, 1'b0);
  endtask

  task automatic test_confirm();
    run(0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (fall_alarm !== 1'b0) begin fails++; $display("FAIL alarm_one_hit got=%b want=0", fall_alarm); end
    run(0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (fall_alarm !== 1'b1) begin fails++; $display("FAIL alarm_two_hits got=%b want=1", fall_alarm); end
    run(0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (fall_alarm !== 1'b1) begin fails++; $display("FAIL alarm_sticky got=%b want=1", fall_alarm); end
    @(negedge clk); alarm_clear = 1'b1;
    @(negedge clk); alarm_clear = 1'b0;
    tests++;
    if (fall_alarm !== 1'b0) begin fails++; $display("FAIL alarm_clear got=%b want=0", fall_alarm); end
    // stray done while accumulating must not count
    @(negedge clk); svm_done = 1'b1; svm_result = 1'b1;
    @(negedge clk); svm_done = 1'b0;
    run(0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (fall_alarm !== 1'b0) begin fails++; $display("FAIL stray_done got=%b want=0", fall_alarm); end
    run(0, 1'b0, 1'b0, 1'b0);
    run(0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (fall_alarm !== 1'b0) begin fails++; $display("FAIL hit_miss_hit got=%b want=0", fall_alarm); end
    run(0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (fall_alarm !== 1'b0) begin fails++; $display("FAIL clear_wins got=%b want=0", fall_alarm); end
    run(0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (fall_alarm !== 1'b0) begin fails++; $display("FAIL clear_zeroes_count got=%b want=0", fall_alarm); end
  endtask

  task automatic test_timeout();
    feed(0, 32, 1'b0);
    wait_start();
    repeat (10) @(negedge clk);
    tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early err=%b busy=%b want 0/1", timeout_err, busy);
    end
    @(negedge clk);
    tests++;
    if (timeout_err !== 1'b1 || sample_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire err=%b ready=%b busy=%b want 1/1/0", timeout_err, sample_ready, busy);
    end
    run(0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (fall_alarm !== 1'b0 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_conf_clear alarm=%b err=%b want 0/1", fall_alarm, timeout_err);
    end
  endtask

  task automatic test_enable_drop();
    bit seen = 1'b0;
    feed(0, 10, 1'b0);
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    tests++;
    if (sample_ready !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL enable_drop ready=%b busy=%b err=%b want 0/0/1", sample_ready, busy, timeout_err);
    end
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (svm_start) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL enable_drop_start got=1 want=0"); end
    feed(2, 32, 1'b0);
    wait_start();
    tests++;
    if (got_lat !== 18 || got_mean !== -32'sd7) begin
      fails++;
      $display("FAIL enable_new_window lat=%0d mean=%0d want 18/-7", got_lat, got_mean);
    end
    respond(1'b0, 1'b0);
  endtask

  task automatic test_reset_sqrt();
    bit seen = 1'b0;
    feed(1, 32, 1'b0);
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL sqrt_busy got=%b want=1", busy); end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({sample_ready, svm_start, fall_alarm, timeout_err, busy} !== 5'b0 ||
        feature_mean !== 32'sd0 || feature_std !== 32'sd0) begin
      fails++;
      $display("FAIL async_reset ctl=%b mean=%0d std=%0d want all zero",
               {sample_ready, svm_start, fall_alarm, timeout_err, busy}, feature_mean, feature_std);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (svm_start) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_start got=1 want=0"); end
    run(0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (got_lat !== 18 || got_mean !== 32'sd100 || got_std !== 32'sd0) begin
      fails++;
      $display("FAIL reset_new_window lat=%0d mean=%0d std=%0d want 18/100/0", got_lat, got_mean, got_std);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    test_stats();
    test_backpressure();
    test_confirm();
    test_timeout();
    test_enable_drop();
    test_reset_sqrt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
